// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller:
// controller states, RISC-V load/store funct3 codes, access size encodings.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } dmemState_e;

    // Access size, taken straight from funct3[1:0]
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } dmemSize_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    localparam logic [2:0] F3_XX = 3'b111;

    // Natural alignment check: an access of N bytes must sit on an N-byte boundary
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [2:0] addrLow);
        logic bad;
        bad = 1'b0;
        case (dmemSize_e'(funct3[1:0]))
            SIZE_H:  bad = addrLow[0];
            SIZE_W:  bad = |addrLow[1:0];
            SIZE_D:  bad = |addrLow;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // 111 has no load or store meaning; stores have no unsigned variants
    function automatic logic isIllegal(input logic we, input logic [2:0] funct3);
        return (funct3 == F3_XX) || (we && funct3[2]);
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane datapath: pulls a 1/2/4/8-byte value out of a doubleword with
// sign or zero extension, and merges right-aligned store data into a doubleword.
module dmem_byte_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  byteOff,
    input  logic [63:0] rdWord,
    input  logic [63:0] wrData,
    output logic [63:0] loadData,
    output logic [63:0] mergedWord
);

    logic [5:0]  shiftAmt;
    logic [63:0] shiftedRd;
    logic [63:0] sizeMask;

    assign shiftAmt  = {byteOff, 3'b000};
    assign shiftedRd = rdWord >> shiftAmt;

    // Extract the addressed lanes and extend them according to funct3
    always_comb begin
        loadData = 64'h0;
        case (funct3)
            F3_B:    loadData = {{56{shiftedRd[7]}},  shiftedRd[7:0]};
            F3_H:    loadData = {{48{shiftedRd[15]}}, shiftedRd[15:0]};
            F3_W:    loadData = {{32{shiftedRd[31]}}, shiftedRd[31:0]};
            F3_D:    loadData = shiftedRd;
            F3_BU:   loadData = {56'h0, shiftedRd[7:0]};
            F3_HU:   loadData = {48'h0, shiftedRd[15:0]};
            F3_WU:   loadData = {32'h0, shiftedRd[31:0]};
            default: loadData = 64'h0;
        endcase
    end

    // Replace only the addressed lanes of the old word with the new store data
    always_comb begin
        sizeMask = 64'h0;
        case (dmemSize_e'(funct3[1:0]))
            SIZE_B:  sizeMask = 64'h0000_0000_0000_00FF;
            SIZE_H:  sizeMask = 64'h0000_0000_0000_FFFF;
            SIZE_W:  sizeMask = 64'h0000_0000_FFFF_FFFF;
            default: sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        mergedWord = (rdWord & ~(sizeMask << shiftAmt)) | ((wrData & sizeMask) << shiftAmt);
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: turns single byte/half/word/double load-store
// requests into doubleword memory reads and writes, using read-modify-write
// for partial stores and reporting misaligned or illegal requests as faults.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);

    // READ lasts MEM_RD_LATENCY+1 cycles; the counter reaches this value in the last one
    localparam logic [2:0] lastCount = 3'(MEM_RD_LATENCY);

    dmemState_e  state;
    dmemState_e  nextState;
    logic [2:0]  waitCnt;
    logic        latWe;
    logic [2:0]  latFunct3;
    logic [63:0] latAddr;
    logic [63:0] latWdata;
    logic [63:0] writeWord;
    logic        accept;
    logic        reqFault;
    logic        readDone;
    logic [63:0] loadData;
    logic [63:0] mergedWord;

    assign accept   = req_valid && req_ready;
    assign reqFault = isIllegal(req_we, req_funct3) || isMisaligned(req_funct3, req_addr[2:0]);
    assign readDone = (state == READ) && (waitCnt == lastCount);

    // Extraction and merging always work on the live memory read data,
    // so the result is ready in the last READ cycle
    dmem_byte_lane uLane (
        .funct3     (latFunct3),
        .byteOff    (latAddr[2:0]),
        .rdWord     (mem_rdata),
        .wrData     (latWdata),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

    // Next-state selection: faults respond at once, full doubleword stores skip the read
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reqFault)
                        nextState = RESP;
                    else if (req_we && (req_funct3 == F3_D))
                        nextState = WRITE;
                    else
                        nextState = READ;
                end
            end
            READ: begin
                if (waitCnt == lastCount)
                    nextState = latWe ? WRITE : RESP;
            end
            WRITE:   nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State, latched request, read wait counter, write word and response registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            waitCnt   <= 3'd0;
            latWe     <= 1'b0;
            latFunct3 <= 3'd0;
            latAddr   <= 64'h0;
            latWdata  <= 64'h0;
            writeWord <= 64'h0;
            rsp_rdata <= 64'h0;
            rsp_fault <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                latWe     <= req_we;
                latFunct3 <= req_funct3;
                latAddr   <= req_addr;
                latWdata  <= req_wdata;
                writeWord <= req_wdata;
            end
            if ((state != READ) && (nextState == READ))
                waitCnt <= 3'd0;
            else if ((state == READ) && (waitCnt != lastCount))
                waitCnt <= waitCnt + 3'd1;
            if (readDone)
                writeWord <= mergedWord;
            if (accept && reqFault) begin
                rsp_rdata <= 64'h0;
                rsp_fault <= 1'b1;
            end else if (readDone && !latWe) begin
                rsp_rdata <= loadData;
                rsp_fault <= 1'b0;
            end else if (state == WRITE) begin
                rsp_rdata <= 64'h0;
                rsp_fault <= 1'b0;
            end
        end
    end

    // Outputs are decoded from state; Reset gates the handshake and strobes so an abort stays silent
    assign req_ready = (state == IDLE) && !Reset;
    assign rsp_valid = (state == RESP) && !Reset;
    assign mem_wr    = (state == WRITE) && !Reset;
    assign mem_addr  = ((state == READ) || (state == WRITE)) ? {latAddr[63:3], 3'b000} : 64'h0;
    assign mem_wdata = (state == WRITE) ? writeWord : 64'h0;

endmodule
